// File: rtl/ser_pkg.sv
// Shared definitions for the serial byte receiver.
//   DATA_W_DEF : default number of data bits per frame
//   state_e    : receiver FSM states (IDLE, DATA, STOP)
package ser_pkg;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;
endpackage

// File: rtl/ser_byte_rx_if.sv
// Serial receiver bus.
//   bit_en    : one-cycle bit-sample strobe (line side -> receiver)
//   s_in      : serial line, idle high (line side -> receiver)
//   d_out     : last correctly framed word (receiver -> downstream)
//   enable    : one-cycle load strobe for d_out (receiver -> downstream)
//   frame_err : one-cycle pulse on a bad stop bit (receiver -> downstream)
//   busy      : receiver is inside a frame (receiver -> downstream)
// master drives the line, slave is the receiver.
interface ser_byte_rx_if
  import ser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              bit_en;
  logic              s_in;
  logic [DATA_W-1:0] d_out;
  logic              enable;
  logic              frame_err;
  logic              busy;

  modport master (
    output bit_en, s_in,
    input  d_out, enable, frame_err, busy
  );

  modport slave (
    input  bit_en, s_in,
    output d_out, enable, frame_err, busy
  );
endinterface

// File: rtl/ser_shift_cnt.sv
// Data shift register plus bit counter for the serial receiver.
//   clk, rst : clock, synchronous active-high reset
//   shift    : shift bit_in into the MSB and advance the counter
//   clr      : restart the counter at bit 0 (start bit seen)
//   bit_in   : serial data bit to shift in
//   word     : shift register contents (LSB-first frame lands right-aligned)
//   last     : counter is on the final data bit
module ser_shift_cnt
  import ser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              clr,
  input  logic              bit_in,
  output logic [DATA_W-1:0] word,
  output logic              last
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift) begin
      // LSB arrives first, so after DATA_W right-shifts it sits at bit 0.
      word <= {bit_in, word[DATA_W-1:1]};
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_LAST);
endmodule

// File: rtl/ser_byte_rx.sv
// Serial byte receiver: start(0), DATA_W data bits LSB-first, stop(1).
// A good stop bit loads d_out and pulses enable the following cycle; a bad
// stop bit pulses frame_err instead and leaves d_out alone.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ser_byte_rx_if slave (bit_en, s_in in; d_out, enable,
//              frame_err, busy out)
module ser_byte_rx
  import ser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  ser_byte_rx_if.slave   bus
);
  state_e            state, state_nx;
  logic              shift, clr, load, err;
  logic [DATA_W-1:0] word;
  logic              last;
  logic [DATA_W-1:0] d_out_q;
  logic              enable_q, frame_err_q;

  ser_shift_cnt #(.DATA_W(DATA_W)) u_shift_cnt (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .clr    (clr),
    .bit_in (bus.s_in),
    .word   (word),
    .last   (last)
  );

  // Every transition is gated by bit_en, so idle cycles hold everything.
  always_comb begin
    state_nx = state;
    shift    = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    err      = 1'b0;
    if (bus.bit_en) begin
      case (state)
        IDLE: if (!bus.s_in) begin
          state_nx = DATA;
          clr      = 1'b1;
        end
        DATA: begin
          shift = 1'b1;
          if (last) state_nx = STOP;
        end
        STOP: begin
          // Back to IDLE right away so a start bit on the very next strobe
          // is accepted.
          state_nx = IDLE;
          if (bus.s_in) load = 1'b1;
          else          err  = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      d_out_q     <= '0;
      enable_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      // Strobes are recomputed every cycle, so they never stretch.
      enable_q    <= load;
      frame_err_q <= err;
      if (load) d_out_q <= word;
    end
  end

  assign bus.d_out     = d_out_q;
  assign bus.enable    = enable_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_ser_byte_rx.sv
module tb_ser_byte_rx;
  import ser_pkg::*;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ncyc;
  exp_t sb[$];
  logic [7:0] ds_q;
  bit   prev_en;
  bit   prev_err;

  ser_byte_rx_if #(.DATA_W(8)) bus ();

  ser_byte_rx #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Downstream register fed by d_out/enable.
  always_ff @(posedge clk) begin
    if (rst) ds_q <= '0;
    else if (bus.enable) ds_q <= bus.d_out;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (prev_en) begin
      checks = checks + 1;
      if (ds_q !== bus.d_out) begin
        errors = errors + 1;
        $display("FAIL downstream_q got %h want %h", ds_q, bus.d_out);
      end
    end
    if (bus.enable === 1'b1 && bus.frame_err === 1'b1) begin
      errors = errors + 1;
      $display("FAIL both_strobes enable=1 frame_err=1 at cycle %0d", ncyc);
    end
    if ((bus.enable === 1'b1 && prev_en) || (bus.frame_err === 1'b1 && prev_err)) begin
      errors = errors + 1;
      $display("FAIL pulse_width strobe longer than one cycle at %0d", ncyc);
    end
    if (bus.enable === 1'b1 || bus.frame_err === 1'b1) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_strobe en=%b err=%b d_out=%h at %0d",
                 bus.enable, bus.frame_err, bus.d_out, ncyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.due != ncyc || e.is_err != (bus.frame_err === 1'b1)) begin
          errors = errors + 1;
          $display("FAIL strobe_timing got err=%b at cycle %0d want err=%b at cycle %0d",
                   bus.frame_err, ncyc, e.is_err, e.due);
        end else if (!e.is_err && bus.d_out !== e.data) begin
          errors = errors + 1;
          $display("FAIL d_out_on_enable got %h want %h", bus.d_out, e.data);
        end
      end
    end
    while (sb.size() > 0 && sb[0].due < ncyc) begin
      errors = errors + 1;
      $display("FAIL missing_strobe err=%b data=%h due %0d", sb[0].is_err, sb[0].data, sb[0].due);
      void'(sb.pop_front());
    end
    prev_en  = (bus.enable === 1'b1);
    prev_err = (bus.frame_err === 1'b1);
  end

  // Entered and left at posedge+1; bit is sampled at the next posedge.
  task automatic send_bit(input logic b, input int gap);
    bus.s_in   = b;
    bus.bit_en = 1'b1;
    @(posedge clk); #1;
    bus.bit_en = 1'b0;
    bus.s_in   = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int gap);
    exp_t e;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(data[i], gap);
    e.is_err = !stop;
    e.data   = data;
    e.due    = ncyc + 2;
    sb.push_back(e);
    send_bit(stop, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.bit_en = 1'b0;
    bus.s_in   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 4;
    if (bus.d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h want 00", bus.d_out); end
    if (bus.enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", bus.enable); end
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    send_frame(8'hA5, 1'b1, 3);
    idle(3);
    checks = checks + 2;
    if (bus.d_out !== 8'hA5) begin errors++; $display("FAIL good_frame_d_out got %h want a5", bus.d_out); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_frame_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 3);
    idle(3);
    checks = checks + 1;
    if (bus.d_out !== 8'hA5) begin errors++; $display("FAIL frame_err_d_out got %h want a5", bus.d_out); end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h01, 1'b1, 0);
    checks = checks + 1;
    if (bus.d_out !== 8'h01) begin errors++; $display("FAIL b2b_first got %h want 01", bus.d_out); end
    send_frame(8'hFF, 1'b1, 0);
    idle(2);
    checks = checks + 1;
    if (bus.d_out !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h want ff", bus.d_out); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    v = 8'h55;
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(v[i], 1);
    // Reset coincides with a bit strobe; reset must win.
    rst        = 1'b1;
    bus.bit_en = 1'b1;
    bus.s_in   = v[4];
    @(posedge clk); #1;
    rst        = 1'b0;
    bus.bit_en = 1'b0;
    bus.s_in   = 1'b1;
    checks = checks + 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b want 0", bus.busy); end
    if (bus.d_out !== 8'h00) begin errors++; $display("FAIL reset_mid_d_out got %h want 00", bus.d_out); end
    idle(4);
    send_frame(8'h12, 1'b1, 1);
    idle(2);
    checks = checks + 1;
    if (bus.d_out !== 8'h12) begin errors++; $display("FAIL after_reset_frame got %h want 12", bus.d_out); end
  endtask

  task automatic test_idle_noise;
    bus.s_in   = 1'b0;
    bus.bit_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks = checks + 1;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_noise_busy cycle %0d got %b want 0", i, bus.busy); end
    end
    bus.s_in = 1'b1;
    idle(2);
    checks = checks + 1;
    if (bus.d_out !== 8'h12) begin errors++; $display("FAIL idle_noise_d_out got %h want 12", bus.d_out); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    ncyc     = 0;
    prev_en  = 1'b0;
    prev_err = 1'b0;
    rst        = 1'b1;
    bus.bit_en = 1'b0;
    bus.s_in   = 1'b1;
    test_reset();
    test_good_frame();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_idle_noise();
    idle(5);
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ser_byte_rx.md
SER_BYTE_RX -- requirements
Module: ser_byte_rx

Interface
REQ-001 Parameter DATA_W, default 8, shall set the number of data bits per frame and the width of d_out.
REQ-002 Port clk, input, 1 bit, shall be the single clock; all state shall update on its rising edge.
REQ-003 Port rst, input, 1 bit, shall be the reset, synchronous and active-high.
REQ-004 Port bit_en, input, 1 bit, shall be the one-cycle bit-sample strobe; s_in is sampled only in cycles where bit_en=1.
REQ-005 Port s_in, input, 1 bit, shall be the serial line: idle high, framed as start(0), DATA_W data bits LSB-first, then stop(1).
REQ-006 Port d_out, output, DATA_W bits, shall be the last correctly framed word; it feeds the downstream register's d_in.
REQ-007 Port enable, output, 1 bit, shall be a one-cycle load strobe for d_out; it feeds the downstream register's enable.
REQ-008 Port frame_err, output, 1 bit, shall be a one-cycle pulse on a bad stop bit.
REQ-009 Port busy, output, 1 bit, shall be 1 whenever state is not IDLE.

Function
REQ-010 The FSM shall have exactly the states IDLE, DATA and STOP; state shall change only in bit_en=1 cycles, except on reset.
REQ-011 IDLE: when bit_en=1 and s_in=0, the FSM shall go to DATA with the bit counter at 0; when bit_en=1 and s_in=1, it shall stay in IDLE.
REQ-012 DATA: on each bit_en=1, the shift register shall right-shift with s_in entering the MSB, and the counter shall increment.
REQ-013 DATA: on the bit_en that samples bit DATA_W-1, the FSM shall go to STOP and the counter shall wrap to 0.
REQ-014 STOP, bit_en=1, s_in=1: d_out shall load the shift register and enable shall be 1 in the next cycle only; the FSM shall go to IDLE.
REQ-015 STOP, bit_en=1, s_in=0: frame_err shall be 1 in the next cycle only, d_out shall be unchanged, enable shall stay 0, and the FSM shall go to IDLE.
REQ-016 Latency: enable shall rise exactly 1 clk after the stop-bit sample cycle; d_out shall be valid in that same cycle and hold until the next good frame.
REQ-017 enable and frame_err shall never both be 1 in one cycle, and neither shall exceed one cycle in width, even when bit_en=1 on consecutive cycles.
REQ-018 A start bit sampled on the bit_en immediately following a stop sample shall be accepted; back-to-back frames shall lose no data.
REQ-019 The counter width shall be clog2(DATA_W)+1 bits; no other arithmetic is permitted.
REQ-020 bit_en=0 in any state shall hold state, counter, shift register and d_out unchanged.

Reset
REQ-021 rst=1 at a rising edge of clk shall set state=IDLE, counter=0, shift register=0, d_out=0, enable=0, frame_err=0 and busy=0.
REQ-022 rst shall override bit_en in the same cycle; a frame in progress shall be discarded with no enable or frame_err pulse.
REQ-023 After rst is released, the first bit_en with s_in=0 shall start a new frame.

Structure
REQ-024 A shared package ser_pkg shall hold the state enum (IDLE, DATA, STOP) and the DATA_W default constant.
REQ-025 The shift register and bit counter shall be one sub-module, ser_shift_cnt (inputs: shift, clr, bit; outputs: word, last); the FSM and output strobes shall stay in ser_byte_rx.

Verification
REQ-026 Frame 0, 0xA5 LSB-first, 1 with bit_en every 4th cycle -> d_out=8'hA5, one enable pulse 1 clk after the stop sample.
REQ-027 Frame 0, 0x3C, then stop bit 0 -> frame_err pulse, enable=0, d_out keeps its prior value 0xA5.
REQ-028 Back-to-back frames 0x01 and 0xFF with bit_en=1 every cycle -> two enable pulses 10 clk apart, d_out=0x01 then 0xFF.
REQ-029 rst asserted after the 4th data bit of 0x55 -> busy=0 next cycle, no pulse; a following frame of 0x12 -> d_out=0x12.
REQ-030 s_in=0 with bit_en=0 for 20 cycles -> state stays IDLE, busy=0, no pulses.
REQ-031 Chain to the downstream enable register -> its output equals d_out one clk after each enable pulse.
